// File: rtl/cnn_window_streamer_pkg.sv
// cnn_stream_pkg: shared sizing for the CNN window streamer.
// Holds the default frame/pixel geometry, the derived packed-window width and
// counter widths, and win_idx(), which gives the bit offset of window element
// (i,j) inside the packed window (i = row from the top, j = column from the left).
package cnn_stream_pkg;

    localparam int DATA_W = 8;   // pixel width in bits
    localparam int IMG_W  = 8;   // pixels per row, must be >= K
    localparam int IMG_H  = 8;   // rows per frame, must be >= K
    localparam int K      = 3;   // window is K x K

    localparam int WIN_W  = K * K * DATA_W;
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);

    function automatic int win_idx(input int i, input int j);
        return (i * K + j) * DATA_W;
    endfunction

endpackage

// File: rtl/cnn_window_streamer_if.sv
// cnn_window_streamer_if: pixel-in / window-out bus of the window streamer.
//   pix_valid, pix_data  -> streamer     pix_ready  <- streamer
//   win_ready            -> streamer     win_valid, win_data, win_zero,
//                                        win_row, win_col, frame_done <- streamer
// Handshake rule for both channels: a transfer happens on the rising clk edge
// where valid && ready are both 1. A source holding valid must keep its
// payload stable until that edge; ready may change freely and may depend
// combinationally on the other channel.
// Modports: master = the streamer, slave = the pixel source / window sink.
interface cnn_window_streamer_if;
    import cnn_stream_pkg::*;

    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              win_valid;
    logic              win_ready;
    logic [WIN_W-1:0]  win_data;
    logic              win_zero;
    logic [ROW_W-1:0]  win_row;
    logic [COL_W-1:0]  win_col;
    logic              frame_done;

    modport master (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, win_data, win_zero, win_row, win_col, frame_done
    );

    modport slave (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, win_data, win_zero, win_row, win_col, frame_done
    );

endinterface

// File: rtl/cnn_window_streamer_line_buffer.sv
// cnn_line_buffer: DEPTH-deep, WIDTH-wide delay line that only advances when
// en is high. dout is the value written DEPTH enabled cycles ago, i.e. the
// pixel one image row above the one currently being written.
// Ports: clk, en (advance), din (new sample), dout (oldest sample).
// Contents are intentionally not reset; the streamer never emits a window that
// depends on entries written before the current frame's first K-1 rows.
module cnn_line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/cnn_window_streamer.sv
// cnn_window_streamer: turns a raster-order pixel stream into every valid
// K x K convolution window, one registered window per output handshake.
// Ports: clk, rst (synchronous, active high), bus (cnn_window_streamer_if.master):
//   pixel input  pix_valid/pix_ready/pix_data,
//   window output win_valid/win_ready/win_data/win_zero/win_row/win_col,
//   frame_done pulses one cycle after the frame's last window is consumed.
// The output stage is a single register, so the pixel path stalls while a
// window is pending and not being taken.
module cnn_window_streamer
    import cnn_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    cnn_window_streamer_if.master bus
);

    logic              pix_ready;
    logic              accept;
    logic              emit;
    logic              col_last;
    logic              row_last;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [DATA_W-1:0] lb_in   [K-1];
    logic [DATA_W-1:0] lb_out  [K-1];
    logic [DATA_W-1:0] new_col [K];
    logic [DATA_W-1:0] win_q   [K][K];
    logic [DATA_W-1:0] win_nx  [K][K];
    logic [WIN_W-1:0]  win_packed;

    logic              win_valid_q;
    logic [WIN_W-1:0]  win_data_q;
    logic              win_zero_q;
    logic [ROW_W-1:0]  win_row_q;
    logic [COL_W-1:0]  win_col_q;
    logic              frame_done_q;

    assign pix_ready = !win_valid_q || bus.win_ready;
    assign accept    = bus.pix_valid && pix_ready;
    // Requiring c >= K-1 also flushes columns left over from the previous row.
    assign emit      = (row_q >= ROW_W'(K-1)) && (col_q >= COL_W'(K-1));
    assign col_last  = (col_q == COL_W'(IMG_W-1));
    assign row_last  = (row_q == ROW_W'(IMG_H-1));

    // Chain of K-1 line buffers: buffer 0 takes the live pixel, buffer n takes
    // buffer n-1's output, so buffer n outputs the pixel n+1 rows above.
    for (genvar n = 0; n < K-1; n++) begin : g_lb
        if (n == 0) begin : g_head
            assign lb_in[n] = bus.pix_data;
        end else begin : g_chain
            assign lb_in[n] = lb_out[n-1];
        end
        cnn_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (DATA_W)
        ) u_lb (
            .clk  (clk),
            .en   (accept),
            .din  (lb_in[n]),
            .dout (lb_out[n])
        );
    end

    // Next window: shift every row one column left and append the new column,
    // oldest row on top, live pixel at the bottom.
    always_comb begin
        new_col[K-1] = bus.pix_data;
        for (int i = 0; i < K-1; i++) begin
            new_col[i] = lb_out[K-2-i];
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) begin
                win_nx[i][j] = win_q[i][j+1];
            end
            win_nx[i][K-1] = new_col[i];
        end
        win_packed = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_packed[win_idx(i, j) +: DATA_W] = win_nx[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_zero_q   <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            frame_done_q <= win_valid_q && bus.win_ready && row_last_win();

            if (win_valid_q && bus.win_ready) begin
                win_valid_q <= 1'b0;
            end

            if (accept) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        win_q[i][j] <= win_nx[i][j];
                    end
                end

                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end

                // A load here overrides the clear above, giving 1 window/clk.
                if (emit) begin
                    win_valid_q <= 1'b1;
                    win_data_q  <= win_packed;
                    win_zero_q  <= (win_packed == '0);
                    win_row_q   <= row_q;
                    win_col_q   <= col_q;
                end
            end
        end
    end

    // True when the held window is the bottom-right window of the frame.
    function automatic logic row_last_win();
        return (win_row_q == ROW_W'(IMG_H-1)) && (win_col_q == COL_W'(IMG_W-1));
    endfunction

    assign bus.pix_ready  = pix_ready;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_data_q;
    assign bus.win_zero   = win_zero_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_window_streamer.sv
// Self-checking bench for cnn_window_streamer.
module tb_cnn_window_streamer;
    import cnn_stream_pkg::*;

    localparam int EXP_W = 1 + ROW_W + COL_W + WIN_W;
    localparam int RAMP  = 0;
    localparam int ZERO  = 1;
    localparam int INV   = 2;
    localparam int RND   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_window_streamer_if bus ();

    cnn_window_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] cur_img [IMG_H][IMG_W];
    int checks     = 0;
    int errors     = 0;
    int win_cnt    = 0;
    int zero_cnt   = 0;
    int done_cnt   = 0;
    int ready_mode = 1;     // 0 = hold low, 1 = hold high, 2 = random
    bit rand_valid = 1'b0;
    bit done_pend  = 1'b0;

    int ramp_first_v [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int inv_first_v  [9] = '{255, 254, 253, 247, 246, 245, 239, 238, 237};
    int bp_win_v     [9] = '{10, 11, 12, 18, 19, 20, 26, 27, 28};
    logic [WIN_W-1:0] ramp_first;
    logic [WIN_W-1:0] inv_first;
    logic [WIN_W-1:0] bp_win;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic finish_report();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [WIN_W-1:0] pack_list(input int v [9]);
        logic [WIN_W-1:0] d = '0;
        for (int k = 0; k < K*K; k++) begin
            d[win_idx(k / K, k % K) +: DATA_W] = DATA_W'(v[k]);
        end
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] pix_val(input int kind, input int r, input int c);
        case (kind)
            RAMP:    return DATA_W'(r * IMG_W + c);
            ZERO:    return '0;
            INV:     return DATA_W'(255 - (r * IMG_W + c));
            default: return DATA_W'($urandom_range(0, 255));
        endcase
    endfunction

    // Reference window straight from the stored image.
    function automatic logic [EXP_W-1:0] make_exp(input int r, input int c);
        logic [WIN_W-1:0] d = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                d[win_idx(i, j) +: DATA_W] = cur_img[r-K+1+i][c-K+1+j];
            end
        end
        return {(d == '0), ROW_W'(r), COL_W'(c), d};
    endfunction

    // ---------------- win_ready driver ----------------
    initial begin
        bus.win_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.win_ready = 1'b0;
                1:       bus.win_ready = 1'b1;
                default: bus.win_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pend = 1'b0;
            end else begin
                if (done_pend || bus.frame_done) begin
                    check("frame_done", bus.frame_done, done_pend);
                end
                done_pend = 1'b0;
                if (bus.win_valid && bus.win_ready) begin
                    got = {bus.win_zero, bus.win_row, bus.win_col, bus.win_data};
                    win_cnt++;
                    if (bus.win_zero) zero_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL window_extra got=%0h exp=none", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check("window", got, exp);
                        done_pend = (exp[WIN_W+COL_W +: ROW_W] == ROW_W'(IMG_H-1)) &&
                                    (exp[WIN_W +: COL_W] == COL_W'(IMG_W-1));
                    end
                end
                if (bus.frame_done) done_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1; pix_valid is low on return.
    task automatic send_pixel(input logic [DATA_W-1:0] d, output bit ok);
        int guard = 0;
        ok = 1'b0;
        if (rand_valid) begin
            while ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        while (!ok && guard < 1000) begin
            @(negedge clk);
            if (bus.pix_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic hold_window(input logic [DATA_W-1:0] next_pix, input logic [WIN_W-1:0] held);
        ready_mode    = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = next_pix;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_pix_ready", bus.pix_ready, 0);
            check("bp_valid", bus.win_valid, 1);
            check("bp_data", bus.win_data, held);
            check("bp_row", bus.win_row, 3);
            check("bp_col", bus.win_col, 4);
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        ready_mode    = 1;
    endtask

    task automatic run_frame(input int kind, input int n_pix, input bit bp,
                             input bit has_first, input logic [WIN_W-1:0] first_win);
        int idx = 0;
        bit ok;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (idx == n_pix) return;
                cur_img[r][c] = pix_val(kind, r, c);
                send_pixel(cur_img[r][c], ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_timeout got=stalled exp=accept r=%0d c=%0d", r, c);
                    finish_report();
                end
                idx++;
                if (r >= K-1 && c >= K-1) exp_q.push_back(make_exp(r, c));
                if (idx == (K-1)*IMG_W + K-1) check("pre_first_valid", bus.win_valid, 0);
                if (idx == (K-1)*IMG_W + K) begin
                    check("first_valid", bus.win_valid, 1);
                    if (has_first) check("first_data", bus.win_data, first_win);
                end
                if (bp && r == 3 && c == 4) hold_window(pix_val(RAMP, 3, 5), bp_win);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        win_cnt  = 0;
        zero_cnt = 0;
        done_cnt = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        checks++;
        errors++;
        $display("FAIL watchdog got=running exp=done");
        finish_report();
    end

    // ---------------- main sequence ----------------
    initial begin
        ramp_first = pack_list(ramp_first_v);
        inv_first  = pack_list(inv_first_v);
        bp_win     = pack_list(bp_win_v);

        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.win_valid, 0);
        check("rst_data", bus.win_data, 0);
        check("rst_zero", bus.win_zero, 0);
        check("rst_row", bus.win_row, 0);
        check("rst_col", bus.win_col, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_pix_ready", bus.pix_ready, 1);
        rst = 1'b0;

        // Ramp frame, always ready.
        clear_counts();
        run_frame(RAMP, IMG_W*IMG_H, 1'b0, 1'b1, ramp_first);
        drain(200);
        check("ramp_windows", win_cnt, 36);
        check("ramp_done", done_cnt, 1);
        check("ramp_zero", zero_cnt, 0);

        // Ramp frame with a 5-cycle stall on window (3,4).
        clear_counts();
        run_frame(RAMP, IMG_W*IMG_H, 1'b1, 1'b1, ramp_first);
        drain(200);
        check("bp_windows", win_cnt, 36);
        check("bp_done", done_cnt, 1);

        // All-zero frame.
        clear_counts();
        run_frame(ZERO, IMG_W*IMG_H, 1'b0, 1'b1, '0);
        drain(200);
        check("zero_windows", win_cnt, 36);
        check("zero_flagged", zero_cnt, 36);
        check("zero_done", done_cnt, 1);

        // Reset after 30 accepts, pending window dropped, then a clean frame.
        clear_counts();
        run_frame(RAMP, 30, 1'b0, 1'b0, '0);
        ready_mode = 0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", bus.win_valid, 0);
        check("mid_rst_data", bus.win_data, 0);
        check("mid_rst_zero", bus.win_zero, 0);
        check("mid_rst_row", bus.win_row, 0);
        check("mid_rst_col", bus.win_col, 0);
        check("mid_rst_done", bus.frame_done, 0);
        exp_q.delete();
        rst        = 1'b0;
        ready_mode = 1;
        clear_counts();
        run_frame(RAMP, IMG_W*IMG_H, 1'b0, 1'b1, ramp_first);
        drain(200);
        check("restart_windows", win_cnt, 36);
        check("restart_done", done_cnt, 1);

        // Two back-to-back frames, second is the inverted ramp.
        clear_counts();
        run_frame(RAMP, IMG_W*IMG_H, 1'b0, 1'b1, ramp_first);
        run_frame(INV, IMG_W*IMG_H, 1'b0, 1'b1, inv_first);
        drain(200);
        check("b2b_windows", win_cnt, 72);
        check("b2b_done", done_cnt, 2);

        // Random valid/ready over three random frames.
        clear_counts();
        rand_valid = 1'b1;
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            run_frame(RND, IMG_W*IMG_H, 1'b0, 1'b0, '0);
        end
        drain(2000);
        check("rand_windows", win_cnt, 108);
        check("rand_done", done_cnt, 3);
        rand_valid = 1'b0;
        ready_mode = 1;

        finish_report();
    end

endmodule
